// File: rtl/fifo_sync_flags_if.sv
// fifo_sync_flags_if: signal bundle for the synchronous FIFO.
//   master modport : producer/consumer side (drives wr_en, din, rd_en, clr_err)
//   slave  modport : FIFO side (drives data, status flags, fill count, error flags)
// clk/rst are not carried here; they stay plain ports on the FIFO.
interface fifo_sync_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) ();
    logic                     wr_en;
    logic [DATA_WIDTH-1:0]    din;
    logic                     rd_en;
    logic                     clr_err;
    logic [DATA_WIDTH-1:0]    dout;
    logic                     dout_valid;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output wr_en, din, rd_en, clr_err,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en, clr_err,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_flags.sv
// fifo_sync_flags: single-clock FIFO with fill count, almost-full/almost-empty
// thresholds, sticky overflow/underflow and selectable read mode.
//   clk : clock, all state on the rising edge
//   rst : asynchronous active-high reset (memory contents are kept)
//   bus : fifo_sync_flags_if.slave
//         in  : wr_en, din, rd_en (pop in FWFT mode), clr_err
//         out : dout, dout_valid, full, empty, almost_full, almost_empty,
//               count, overflow, underflow
// FWFT=0: dout is registered, dout_valid pulses one cycle after an accepted read.
// FWFT=1: dout shows the head entry combinationally, dout_valid = ~empty.
module fifo_sync_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    fifo_sync_flags_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  overflow_q;
    logic                  underflow_q;

    // Flags decode the registered count only: no write-to-read bypass.
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);
    assign wr_acc = bus.wr_en & ~full;
    assign rd_acc = bus.rd_en & ~empty;

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;

    // Storage has no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= bus.din;
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc && !rd_acc)      count_q <= count_q + CW'(1);
            else if (!wr_acc && rd_acc) count_q <= count_q - CW'(1);
        end
    end

    // Sticky errors: a new error in the clearing cycle wins over clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (bus.wr_en && full)  overflow_q <= 1'b1;
            else if (bus.clr_err)   overflow_q <= 1'b0;
            if (bus.rd_en && empty) underflow_q <= 1'b1;
            else if (bus.clr_err)   underflow_q <= 1'b0;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign bus.dout       = mem[rd_ptr];
            assign bus.dout_valid = ~empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            logic                  dout_valid_q;

            // dout holds its last value between reads; valid is a 1-cycle pulse.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else begin
                    dout_valid_q <= rd_acc;
                    if (rd_acc) dout_q <= mem[rd_ptr];
                end
            end

            assign bus.dout       = dout_q;
            assign bus.dout_valid = dout_valid_q;
        end
    endgenerate
endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb_fifo_sync_flags: drives a standard-mode and an FWFT-mode FIFO with the
// same stimulus and compares both against a queue-based reference model.
module tb_fifo_sync_flags;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;
    logic [DW-1:0] din = '0;

    always #5 clk = ~clk;

    fifo_sync_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_std ();
    fifo_sync_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus_ff ();

    assign bus_std.wr_en   = wr_en;
    assign bus_std.din     = din;
    assign bus_std.rd_en   = rd_en;
    assign bus_std.clr_err = clr_err;
    assign bus_ff.wr_en    = wr_en;
    assign bus_ff.din      = din;
    assign bus_ff.rd_en    = rd_en;
    assign bus_ff.clr_err  = clr_err;

    fifo_sync_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) u_std (
        .clk (clk),
        .rst (rst),
        .bus (bus_std.slave)
    );

    fifo_sync_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (bus_ff.slave)
    );

    // Reference model: contents as a queue, plus sticky flags and the
    // standard-mode output register.
    logic [DW-1:0] q[$];
    bit            m_ovf;
    bit            m_unf;
    logic [DW-1:0] m_dout;
    bit            m_dv;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("std.count",     32'(bus_std.count), 32'(n));
        chk("std.full",      32'(bus_std.full), 32'(n == DEPTH));
        chk("std.empty",     32'(bus_std.empty), 32'(n == 0));
        chk("std.af",        32'(bus_std.almost_full), 32'(n >= DEPTH - 2));
        chk("std.ae",        32'(bus_std.almost_empty), 32'(n <= 2));
        chk("std.overflow",  32'(bus_std.overflow), 32'(m_ovf));
        chk("std.underflow", 32'(bus_std.underflow), 32'(m_unf));
        chk("std.dout_valid",32'(bus_std.dout_valid), 32'(m_dv));
        chk("std.dout",      32'(bus_std.dout), 32'(m_dout));
        chk("ff.count",      32'(bus_ff.count), 32'(n));
        chk("ff.overflow",   32'(bus_ff.overflow), 32'(m_ovf));
        chk("ff.underflow",  32'(bus_ff.underflow), 32'(m_unf));
        chk("ff.dout_valid", 32'(bus_ff.dout_valid), 32'(n != 0));
        if (n != 0) chk("ff.dout", 32'(bus_ff.dout), 32'(q[0]));
    endtask

    // One clock cycle: apply inputs, advance the model from pre-edge state,
    // then compare after the edge.
    task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
        int n;
        bit wa;
        bit ra;
        wr_en = w; din = d; rd_en = r; clr_err = c;
        n  = q.size();
        wa = w && (n < DEPTH);
        ra = r && (n > 0);
        @(posedge clk); #1;
        if (w && n == DEPTH) m_ovf = 1'b1;
        else if (c)          m_ovf = 1'b0;
        if (r && n == 0)     m_unf = 1'b1;
        else if (c)          m_unf = 1'b0;
        m_dv = ra;
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(d);
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        check_all();
    endtask

    // Reset asserted between clock edges; effects must be visible before any edge.
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_dv = 1'b0;
        check_all();
        @(posedge clk); #1;
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        logic [DW-1:0] d;
        int p;
        q.delete();
        m_ovf = 1'b0; m_unf = 1'b0; m_dout = '0; m_dv = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Fill to full, overflow attempt, drain in order
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b0, '0, 1'b1, 1'b0);
            chk("drain.order", 32'(bus_std.dout), 32'(i));
        end
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Underflow, clear, then read+clear together while empty
        cyc(1'b0, '0, 1'b1, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Steady state at count=5 with simultaneous traffic across wraps
        for (int i = 0; i < 5; i++) cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, DW'(8'h85 + i), 1'b1, 1'b0);
            chk("steady.delay5", 32'(bus_std.dout), 32'(8'h80 + i));
        end
        for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1, 1'b0);

        // FWFT: a single write into empty shows up without a read
        cyc(1'b1, 8'h3C, 1'b0, 1'b0);
        chk("fwft.3c", 32'(bus_ff.dout), 32'h3C);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("fwft.drained", 32'(bus_ff.dout_valid), 32'd0);

        // Full: read+write together, write dropped
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full.rdwr.count", 32'(bus_std.count), 32'(DEPTH - 1));
        cyc(1'b0, '0, 1'b0, 1'b1);

        // Async reset mid-stream at count=9, then 0x55 round trip
        async_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
        async_reset();
        cyc(1'b1, 8'h55, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        chk("rst.55", 32'(bus_std.dout), 32'h55);

        // Randomized traffic with shifting fill/drain bias
        for (int blk = 0; blk < 10; blk++) begin
            p = int'($urandom_range(15, 85));
            for (int i = 0; i < 80; i++) begin
                d = DW'($urandom);
                cyc(int'($urandom_range(99)) < p, d,
                    int'($urandom_range(99)) >= p - 10,
                    $urandom_range(19) == 0);
            end
            if ($urandom_range(2) == 0) async_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
- Next-generation single-clock synchronous FIFO. Storage, pointer control and flag logic live in one block.
- Adds a fill-level count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable read mode: registered-output standard, or first-word-fall-through (FWFT).
- Used as the general buffering primitive between producer/consumer stages in the datapath.

Parameters:
- DATA_WIDTH, 8, bits per entry.
- DEPTH, 16, number of entries; power of two, >= 4.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1.
- FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (FWFT: pop/acknowledge of the head entry).
- clr_err  in  1  clears overflow/underflow.
- dout  out  DATA_WIDTH  read data.
- dout_valid  out  1  dout holds valid data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  $clog2(DEPTH)+1  current number of stored entries.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (async, rst=1):
  - Pointers and count go to 0; dout=0; dout_valid=0; overflow=0; underflow=0.
  - Hence empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not reset.
- Accept rules use registered state only:
  - wr_acc = wr_en & ~full.
  - rd_acc = rd_en & ~empty.
  - A write while full is dropped. A read while full is still accepted, but a write in that same cycle is dropped.
- Storage and count:
  - wr_acc stores din at wr_ptr; wr_ptr increments modulo DEPTH.
  - rd_acc increments rd_ptr modulo DEPTH.
  - count <= count + wr_acc - rd_acc. Simultaneous accepted read and write leave count unchanged.
- Flags:
  - full, empty, almost_full and almost_empty are combinational decodes of the count register. They therefore change the cycle after the causing edge.
  - No bypass: a write into an empty FIFO deasserts empty one cycle later.
- Standard mode (FWFT=0):
  - On rd_acc, dout <= mem[rd_ptr] and dout_valid <= 1 for exactly one cycle (1-cycle read latency).
  - Without rd_acc, dout holds its last value and dout_valid <= 0.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] combinationally; dout_valid = ~empty.
  - rd_acc consumes the head; the next entry appears the following cycle.
  - Data written into an empty FIFO appears on dout one cycle after the write edge.
- Error flags:
  - overflow <= 1 when wr_en & full.
  - underflow <= 1 when rd_en & empty.
  - Both hold until clr_err=1. If set and clear occur in the same cycle, set wins.
  - A dropped access changes no pointer, count or memory entry.
- Wrap-around: pointers wrap silently. Ordering is preserved across any number of wraps.
- Reset mid-operation: all stored data is discarded immediately. The first post-reset write is read back first.

Test Plan:
- Reset, then 16 writes of 0x00..0x0F (DEPTH=16) → count=16, full=1, almost_full asserted from count=14. A 17th write of 0xAA → overflow=1, count stays 16. 16 reads then return 0x00..0x0F in order with no 0xAA.
- Empty FIFO, rd_en=1 for one cycle → underflow=1, count=0, dout unchanged. clr_err pulse → underflow=0. rd_en and clr_err together while empty → underflow stays 1.
- count=5, wr_en and rd_en held for 40 cycles with incrementing data → count stays 5, pointers wrap at least twice, and the output sequence equals the input sequence delayed by 5 entries.
- FWFT=1: write 0x3C into an empty FIFO → next cycle dout=0x3C with dout_valid=1 and no rd_en needed. rd_en → empty=1 and dout_valid=0 one cycle later.
- FWFT=0 with full=1: rd_en and wr_en together → read accepted, write dropped, overflow=1, count=15.
- Mid-stream with count=9, assert rst asynchronously (between clock edges) → count=0, empty=1, dout=0, flags cleared immediately. A subsequent write of 0x55 and a read return 0x55.
